fetch_unit: RTL and testbench

//  Instruction-fetch stage; drives the IF/ID pipeline register (PC, inst, enable, flush).

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_STEP     = 32'd4;
   localparam logic [31:0] BUBBLE_INST = 32'd0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_slot_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests and
// feeds the IF/ID register with instructions, holds on stall and bubbles on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] PC_o,
   output logic [31:0] inst_o,
   output logic        ifid_enable_o,
   output logic        ifid_flush_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   fetch_slot_t  hold_q, hold_d;

   logic         deliver;
   fetch_slot_t  cand;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         hold_q   <= hold_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      hold_d   = hold_q;

      unique case (state_q)
         REQ: begin
            if (imem_gnt_i) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + PC_STEP;
               // A fetch granted alongside a redirect is wrong-path and must be drained.
               state_d  = redirect_i ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (!redirect_i && stall_i) begin
                  hold_d  = '{pc: req_pc_q, inst: imem_rdata_i};
                  state_d = HOLD;
               end else begin
                  state_d = REQ;
               end
            end else if (redirect_i) begin
               state_d = DRAIN;
            end
         end
         HOLD: begin
            if (redirect_i) begin
               hold_d  = '0;
               state_d = REQ;
            end else if (!stall_i) begin
               state_d = REQ;
            end
         end
         DRAIN: begin
            // The outstanding response is discarded even if a new redirect arrives with it.
            if (imem_rvalid_i) state_d = REQ;
         end
         default: state_d = REQ;
      endcase

      if (redirect_i) pc_d = redirect_pc_i & ~32'd3;
   end

   always_comb begin
      cand = '{pc: BUBBLE_INST, inst: BUBBLE_INST};
      deliver = 1'b0;
      if (state_q == HOLD) begin
         cand    = hold_q;
         deliver = !redirect_i && !stall_i;
      end else if (state_q == WAIT && imem_rvalid_i) begin
         cand    = '{pc: req_pc_q, inst: imem_rdata_i};
         deliver = !redirect_i && !stall_i;
      end
   end

   always_comb begin
      imem_req_o  = (state_q == REQ);
      imem_addr_o = pc_q;
      if (deliver) begin
         PC_o          = cand.pc;
         inst_o        = cand.inst;
         ifid_enable_o = 1'b1;
         ifid_flush_o  = 1'b0;
      end else begin
         // No instruction this cycle: write a bubble unless the stall must freeze IF/ID.
         PC_o          = BUBBLE_INST;
         inst_o        = BUBBLE_INST;
         ifid_enable_o = redirect_i | ~stall_i;
         ifid_flush_o  = redirect_i | ~stall_i;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized imem/stall/redirect traffic checked against a transaction-level model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect, gnt, rvalid;
   logic [31:0] rpc, rdata;
   logic        req, en, fl;
   logic [31:0] addr, pc_o, inst_o;

   logic        zero = 1'b0;
   logic [31:0] zero32 = 32'd0;
   logic        gnt2, rvalid2;
   logic [31:0] rdata2;
   logic        req2, en2, fl2;
   logic [31:0] addr2, pc2, inst2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
      .redirect_pc_i(rpc), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .PC_o(pc_o), .inst_o(inst_o),
      .ifid_enable_o(en), .ifid_flush_o(fl)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .stall_i(zero), .redirect_i(zero),
      .redirect_pc_i(zero32), .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
      .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2), .PC_o(pc2), .inst_o(inst2),
      .ifid_enable_o(en2), .ifid_flush_o(fl2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic r, input logic [31:0] a,
                          input logic [31:0] p, input logic [31:0] i,
                          input logic e, input logic f);
      chk({tag, ".req"},   32'(req),  32'(r));
      chk({tag, ".addr"},  addr,      a);
      chk({tag, ".pc"},    pc_o,      p);
      chk({tag, ".inst"},  inst_o,    i);
      chk({tag, ".en"},    32'(en),   32'(e));
      chk({tag, ".flush"}, 32'(fl),   32'(f));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch from REQ, leaves the DUT back in REQ.
   task automatic fetch0(input logic [31:0] data);
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = data;
      tick();
      rvalid = 1'b0;
   endtask

   // rvalid may only answer an outstanding request, never while a new one is offered.
   always @(negedge clk) begin
      if (!reset && rvalid) begin
         checks++;
         assert (!req) else begin
            errors++;
            $display("FAIL protocol: rvalid=1 while req=%0b at %0t", req, $time);
         end
      end
   end

   // Transaction-level model state
   logic [31:0] m_pc, m_out_pc, m_hpc, m_hinst;
   logic        m_busy, m_live, m_held;
   // Bench imem state
   logic        mem_pend;
   int          mem_lat;
   logic [31:0] mem_data;

   initial begin
      reset = 1'b1; stall = 0; redirect = 0; gnt = 0; rvalid = 0; rpc = 0; rdata = 0;
      gnt2 = 0; rvalid2 = 0; rdata2 = 0;

      // 1: reset outputs
      for (int k = 0; k < 3; k++) begin
         tick();
         #1 chk_out("t1_reset", 1, 32'h0, 0, 0, 1, 1);
      end
      reset = 1'b0;
      #1 chk_out("t1_post", 1, 32'h0, 0, 0, 1, 1);

      // 2: zero-wait fetch
      tick(); gnt = 1;
      #1 chk_out("t2_req", 1, 32'h0, 0, 0, 1, 1);
      tick(); gnt = 0; rvalid = 1; rdata = 32'h0050_0093;
      #1 chk_out("t2_deliver", 0, 32'h4, 32'h0, 32'h0050_0093, 1, 0);
      tick(); rvalid = 0;
      #1 chk_out("t2_next", 1, 32'h4, 0, 0, 1, 1);

      // 3: stall at rvalid for PC 0x8, held 3 cycles
      fetch0(32'h0000_0011);
      gnt = 1;
      tick(); gnt = 0; rvalid = 1; stall = 1; rdata = 32'h1234_5678;
      #1 chk_out("t3_stall1", 0, 32'hC, 0, 0, 0, 0);
      tick(); rvalid = 0;
      #1 chk_out("t3_stall2", 0, 32'hC, 0, 0, 0, 0);
      tick();
      #1 chk_out("t3_stall3", 0, 32'hC, 0, 0, 0, 0);
      tick(); stall = 0;
      #1 chk_out("t3_release", 0, 32'hC, 32'h8, 32'h1234_5678, 1, 0);
      tick();
      #1 chk_out("t3_next", 1, 32'hC, 0, 0, 1, 1);

      // 4: redirect while waiting for the 0x10 response
      fetch0(32'h0000_0022);
      gnt = 1;
      tick(); gnt = 0; redirect = 1; rpc = 32'h0000_0103;
      #1 chk_out("t4_redirect", 0, 32'h14, 0, 0, 1, 1);
      tick(); redirect = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
      #1 chk_out("t4_drop", 0, 32'h100, 0, 0, 1, 1);
      tick(); rvalid = 0;
      #1 chk_out("t4_next", 1, 32'h100, 0, 0, 1, 1);

      // 5: redirect coincident with gnt under stall
      gnt = 1; redirect = 1; rpc = 32'h0000_0200; stall = 1;
      #1 chk_out("t5_redirect", 1, 32'h100, 0, 0, 1, 1);
      tick(); gnt = 0; redirect = 0; stall = 0;
      #1 chk_out("t5_drain", 0, 32'h200, 0, 0, 1, 1);
      tick(); rvalid = 1; rdata = 32'hCAFE_0001;
      #1 chk_out("t5_drained", 0, 32'h200, 0, 0, 1, 1);
      tick(); rvalid = 0;
      #1 chk_out("t5_next", 1, 32'h200, 0, 0, 1, 1);

      // Reset while a fetch is outstanding
      gnt = 1;
      tick(); gnt = 0;
      #1 chk_out("rst_wait", 0, 32'h204, 0, 0, 1, 1);
      reset = 1;
      #1 chk_out("rst_mid_wait", 1, 32'h0, 0, 0, 1, 1);
      tick(); reset = 0;

      // Randomized traffic against the model
      m_pc = 32'h0; m_busy = 0; m_live = 0; m_held = 0;
      m_out_pc = 0; m_hpc = 0; m_hinst = 0;
      mem_pend = 0; mem_lat = 0; mem_data = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic        r_exp, e_exp, f_exp, have;
         logic [31:0] p_exp, i_exp, c_pc, c_inst;
         tick();
         stall    = ($urandom_range(0, 2) == 0);
         redirect = ($urandom_range(0, 9) == 0);
         rpc      = $urandom_range(0, 4095);
         gnt      = $urandom_range(0, 1) == 1;
         rvalid   = mem_pend && (mem_lat == 0);
         rdata    = rvalid ? mem_data : $urandom();
         #1;
         r_exp  = !m_busy && !m_held;
         have   = m_held || (m_busy && rvalid && m_live);
         c_pc   = m_held ? m_hpc : m_out_pc;
         c_inst = m_held ? m_hinst : rdata;
         if (redirect) begin
            p_exp = 0; i_exp = 0; e_exp = 1; f_exp = 1;
         end else if (have && !stall) begin
            p_exp = c_pc; i_exp = c_inst; e_exp = 1; f_exp = 0;
         end else begin
            p_exp = 0; i_exp = 0; e_exp = !stall; f_exp = !stall;
         end
         chk_out("rand", r_exp, m_pc, p_exp, i_exp, e_exp, f_exp);

         if (rvalid) mem_pend = 0;
         if (req && gnt) begin
            mem_pend = 1; mem_lat = $urandom_range(0, 3); mem_data = $urandom();
         end else if (mem_pend && mem_lat > 0) begin
            mem_lat--;
         end

         if (m_held) begin
            if (redirect || !stall) m_held = 0;
         end else if (m_busy && rvalid) begin
            m_busy = 0;
            if (m_live && !redirect && stall) begin
               m_held = 1; m_hpc = m_out_pc; m_hinst = rdata;
            end
         end else if (m_busy && redirect) begin
            m_live = 0;
         end
         if (r_exp && gnt) begin
            m_busy = 1; m_out_pc = m_pc; m_live = !redirect;
         end
         if (redirect) m_pc = rpc & ~32'd3;
         else if (r_exp && gnt) m_pc = m_pc + 32'd4;
      end

      // 6: PC wraps from 0xFFFF_FFFC to 0
      tick();
      stall = 0; redirect = 0; gnt = 0; rvalid = 0;
      reset = 1;
      tick(); reset = 0;
      tick(); gnt2 = 1;
      #1 chk("t6_addr0", addr2, 32'hFFFF_FFFC);
      chk("t6_req0", 32'(req2), 32'd1);
      tick(); gnt2 = 0; rvalid2 = 1; rdata2 = 32'h0000_AAAA;
      #1 chk("t6_pc0", pc2, 32'hFFFF_FFFC);
      chk("t6_inst0", inst2, 32'h0000_AAAA);
      chk("t6_en0", 32'(en2), 32'd1);
      chk("t6_fl0", 32'(fl2), 32'd0);
      tick(); rvalid2 = 0; gnt2 = 1;
      #1 chk("t6_addr_wrap", addr2, 32'h0000_0000);
      chk("t6_req1", 32'(req2), 32'd1);
      tick(); gnt2 = 0; rvalid2 = 1; rdata2 = 32'h0000_BBBB;
      #1 chk("t6_pc1", pc2, 32'h0000_0000);
      chk("t6_inst1", inst2, 32'h0000_BBBB);
      tick(); rvalid2 = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
